pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit that produces the 6-bit stall vector consumed by the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates stall requests from ID (load-use), EX (multi-cycle unit, e.g. divider) and MEM (data-bus wait).
- Owns the start/done handshake and timeout watchdog for the EX multi-cycle unit.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- TIMEOUT, 64, max cycles in EX_WAIT before abort (≥2).
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- stallreq_id  in  1  ID load-use stall request (level, combinational from ID)
- ex_mc_req  in  1  instruction in EX needs multi-cycle unit (level, held while instruction sits in EX)
- ex_mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
- mem_req  in  1  MEM stage data-bus access active
- mem_ack  in  1  data-bus acknowledge
- perf_clr  in  1  synchronous clear of stall_cycles
- stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop
- mc_start  out  1  1-cycle start pulse to multi-cycle unit
- mc_abort  out  1  1-cycle abort pulse on timeout
- mc_hold  out  1  multi-cycle result complete but EX frozen by MEM stall; unit must hold result
- mc_timeout  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1

Behaviour:
- State register: IDLE, EX_WAIT, HOLD; async reset to IDLE.
- stall, mc_start, mc_abort, mc_hold are combinational from state and inputs.
  - They are valid in the same cycle as the request, so pipeline registers sample them at the next posedge.
- mem_stall = mem_req & ~mem_ack. There is no state for MEM, and it is evaluated every cycle.
- ex_stall, by state:
  - IDLE: ex_stall = ex_mc_req.
  - EX_WAIT: ex_stall = ~ex_mc_done.
  - HOLD: ex_stall = 0; ex_mc_req is masked.
- Stall encoding, highest priority first:
  - mem_stall → 6'b011111
  - ex_stall → 6'b001111
  - stallreq_id → 6'b000111
  - otherwise 6'b000000
- Transitions:
  - IDLE → EX_WAIT: when ex_mc_req=1. mc_start=1 in this cycle only.
    - This applies even if mem_stall=1; the unit runs in parallel.
  - EX_WAIT, ex_mc_done=1, mem_stall=0 → IDLE. The EX instruction advances at this edge, and ex_mc_req is ignored in this cycle.
  - EX_WAIT, ex_mc_done=1, mem_stall=1 → HOLD.
  - EX_WAIT, wait counter reaches TIMEOUT-1 without done → IDLE.
    - mc_abort=1 for that cycle; mc_timeout set (sticky until rst).
    - stall in the abort cycle = 6'b001111. The EX instruction stays and re-requests next cycle.
  - HOLD: mc_hold=1. When mem_stall=0 → IDLE; the instruction advances at that edge.
- Wait counter:
  - Cleared on entry to EX_WAIT, increments each EX_WAIT cycle.
  - Width is clog2(TIMEOUT).
- stall_cycles:
  - Increments when stall[0]=1 and saturates at all-ones.
  - perf_clr has priority over increment, giving 0 next cycle.
- While rst=1:
  - stall=0, mc_start=0, mc_abort=0, mc_hold=0.
  - stall_cycles=0, mc_timeout=0, state IDLE.
- Reset mid-operation (EX_WAIT/HOLD) returns to IDLE immediately with no abort pulse.
- Simultaneous done and timeout in the same cycle: done wins, with no abort and no timeout flag.
- mc_start is never asserted outside IDLE. A new multi-cycle request is accepted only from IDLE.

Test Plan:
- Reset asserted asynchronously mid-EX_WAIT → stall=000000, state IDLE, stall_cycles=0 without waiting for a clock edge.
- stallreq_id=1 for one cycle, nothing else → stall=000111 that cycle; stall_cycles=1 afterwards.
- ex_mc_req=1 held, ex_mc_done pulses 5 cycles after mc_start → mc_start one cycle.
  - stall=001111 for 5 cycles, then 000000 in the done cycle.
  - stall_cycles=5.
- mem_req=1, mem_ack=0 for 3 cycles while stallreq_id=1 → stall=011111 for 3 cycles, then 000111 once mem_ack=1.
- Done arrives while mem_stall=1 for 2 more cycles → mc_hold=1 and stall=011111 for those cycles.
  - Then IDLE with stall=000000; no second mc_start although ex_mc_req still high.
- TIMEOUT=8, ex_mc_req held, no done → mc_abort on the 8th EX_WAIT cycle, mc_timeout=1 sticky, mc_start again next cycle.
  - With CNT_W=4 and a long stall, stall_cycles saturates at 15; perf_clr gives 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall arbiter with multi-cycle EX unit handshake, timeout watchdog
// and a saturating stall-cycle performance counter.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_req,
  input  logic             ex_mc_done,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             perf_clr,
  output logic [5:0]       stall,
  output logic             mc_start,
  output logic             mc_abort,
  output logic             mc_hold,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StExWait, StHold} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout_q;
  logic               mem_stall, ex_stall, timeout_hit;

  assign mem_stall   = mem_req & ~mem_ack;
  assign timeout_hit = (wait_q == WaitW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ex_stall = 1'b0;
    mc_start = 1'b0;
    mc_abort = 1'b0;
    mc_hold  = 1'b0;
    case (state_q)
      StIdle: begin
        ex_stall = ex_mc_req;
        if (ex_mc_req) begin
          mc_start = 1'b1;
          wait_d   = '0;
          state_d  = StExWait;
        end
      end
      StExWait: begin
        ex_stall = ~ex_mc_done;
        wait_d   = wait_q + 1'b1;
        // Done takes precedence over a coincident timeout.
        if (ex_mc_done) begin
          state_d = mem_stall ? StHold : StIdle;
        end else if (timeout_hit) begin
          mc_abort = 1'b1;
          state_d  = StIdle;
        end
      end
      StHold: begin
        mc_hold = 1'b1;
        if (!mem_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Outputs are forced quiet while reset is held.
    if (rst) begin
      ex_stall = 1'b0;
      mc_start = 1'b0;
      mc_abort = 1'b0;
      mc_hold  = 1'b0;
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (rst)              stall = 6'b000000;
    else if (mem_stall)   stall = 6'b011111;
    else if (ex_stall)    stall = 6'b001111;
    else if (stallreq_id) stall = 6'b000111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | mc_abort;
      if (perf_clr) begin
        cnt_q <= '0;
      end else if (stall[0] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign mc_timeout   = timeout_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: expected outputs are queued as stimulus is
// driven and compared at the following negative clock edge.
module tb_pipe_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stallreq_id = 1'b0, ex_mc_req = 1'b0, ex_mc_done = 1'b0;
  logic             mem_req = 1'b0, mem_ack = 1'b0, perf_clr = 1'b0;
  logic [5:0]       stall;
  logic             mc_start, mc_abort, mc_hold, mc_timeout;
  logic [CNT_W-1:0] stall_cycles;

  // {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles}
  logic [13:0]      sb[$];
  logic [13:0]      got, exp_v;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_to;
  int               n_chk = 0;
  int               n_bad = 0;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_req(ex_mc_req),
    .ex_mc_done(ex_mc_done), .mem_req(mem_req), .mem_ack(mem_ack), .perf_clr(perf_clr),
    .stall(stall), .mc_start(mc_start), .mc_abort(mc_abort), .mc_hold(mc_hold),
    .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // in = {stallreq_id, ex_mc_req, ex_mc_done, mem_req, mem_ack, perf_clr}
  // sah = {mc_start, mc_abort, mc_hold}
  task automatic step(input logic [5:0] in, input logic [5:0] es, input logic [2:0] sah);
    {stallreq_id, ex_mc_req, ex_mc_done, mem_req, mem_ack, perf_clr} = in;
    sb.push_back({es, sah, exp_to, exp_cnt});
    if (sah[1]) exp_to = 1'b1;
    if (in[0]) exp_cnt = '0;
    else if (es[0] && exp_cnt != 4'hf) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    stallreq_id = 1'b1; ex_mc_req = 1'b1; mem_req = 1'b1;
    #2;
    got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
    n_chk++;
    if (got !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_hold got=%h exp=%h", got, 14'h0);
    end
    stallreq_id = 1'b0; ex_mc_req = 1'b0; mem_req = 1'b0;
    exp_cnt = '0; exp_to = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_id_stall();
    for (int i = 0; i < 2; i++) begin
      step({(i == 0), 5'b0}, (i == 0) ? 6'h07 : 6'h00, 3'b000);
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL id_stall cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mc_done();
    for (int i = -1; i < 7; i++) begin
      if (i < 0) step(6'b000001, 6'h00, 3'b000);
      else step({1'b0, (i < 6), (i == 5), 3'b000}, (i < 5) ? 6'h0f : 6'h00,
                {(i == 0), 2'b00});
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL mc_done cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_priority();
    for (int i = 0; i < 5; i++) begin
      if (i < 3)       step(6'b100100, 6'h1f, 3'b000);
      else if (i == 3) step(6'b100110, 6'h07, 3'b000);
      else             step(6'b000000, 6'h00, 3'b000);
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL mem_priority cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       step(6'b010000, 6'h0f, 3'b100);
        1:       step(6'b010100, 6'h1f, 3'b000);
        2:       step(6'b011100, 6'h1f, 3'b000);
        3, 4:    step(6'b010100, 6'h1f, 3'b001);
        5:       step(6'b010000, 6'h00, 3'b001);
        default: step(6'b000000, 6'h00, 3'b000);
      endcase
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL hold cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_done_vs_timeout();
    for (int i = 0; i < 10; i++) begin
      step({1'b0, (i <= 8), (i == 8), 3'b000}, (i < 8) ? 6'h0f : 6'h00, {(i == 0), 2'b00});
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL done_vs_timeout cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 12; i++) begin
      step({1'b0, (i <= 10), (i == 10), 3'b000}, (i < 10) ? 6'h0f : 6'h00,
           {(i == 0 || i == 9), (i == 8), 1'b0});
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL timeout cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf_sat();
    for (int i = 0; i < 22; i++) begin
      if (i < 20)       step(6'b100000, 6'h07, 3'b000);
      else if (i == 20) step(6'b000001, 6'h00, 3'b000);
      else              step(6'b000000, 6'h00, 3'b000);
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL perf_sat cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      step(6'b010000, 6'h0f, {(i == 0), 2'b00});
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL async_reset_pre cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
    // Reset asserted between edges while the unit is busy.
    #1 rst = 1'b1;
    #1;
    got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
    n_chk++;
    if (got !== 14'h0) begin
      n_bad++; $display("FAIL async_reset_mid got=%h exp=%h", got, 14'h0);
    end
    exp_cnt = '0; exp_to = 1'b0;
    ex_mc_req = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // Back in IDLE: a request must start the unit again.
    for (int i = 0; i < 3; i++) begin
      step({1'b0, (i < 2), (i == 1), 3'b000}, (i == 0) ? 6'h0f : 6'h00, {(i == 0), 2'b00});
      got = {stall, mc_start, mc_abort, mc_hold, mc_timeout, stall_cycles};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL async_reset_post cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_mc_done();
    test_mem_priority();
    test_hold();
    test_done_vs_timeout();
    test_timeout();
    test_perf_sat();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
